pc_target_table: RTL and testbench

PC_TARGET_TABLE -- requirements
Module: pc_target_table

---
 rtl/pc_target_table.sv | 141 ++++++++++++++
 tb/tb_pc_target_table.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_target_table.sv
// ============================================================================
// Module  : pc_target_table
// Purpose : Direct-mapped branch-target table. The valid bits are cleared
//           one entry per cycle in INIT, and lookups take one cycle.
// Config  : define TGT_BYPASS_EN to forward write data to a same-index lookup
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_target_table #(
  parameter int D = 9,
  parameter int A = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         wr_en,
  input  logic [A-1:0] wr_addr,
  input  logic [D-1:0] wr_data,
  input  logic         rd_req,
  input  logic [A-1:0] rd_addr,
  output logic         busy,
  output logic         rd_valid,
  output logic         rd_hit,
  output logic [D-1:0] target
);

  localparam int DEPTH = 1 << A;

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [A-1:0]     init_ptr_q, init_ptr_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic             rd_valid_q, rd_valid_d;
  logic             rd_hit_q, rd_hit_d;
  logic [D-1:0]     target_q, target_d;
  logic [D-1:0]     mem_q [DEPTH];

  logic             wr_accept;
  logic             rd_accept;
  logic             rd_entry_valid;
  logic [D-1:0]     rd_entry_data;

  // Requests are only honoured in READY, and flush takes precedence over both.
  assign wr_accept = (state_q == ST_READY) && !flush && wr_en;
  assign rd_accept = (state_q == ST_READY) && !flush && rd_req;

  assign rd_entry_valid = valid_q[rd_addr];
  assign rd_entry_data  = mem_q[rd_addr];

  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    valid_d    = valid_q;
    rd_valid_d = 1'b0;
    rd_hit_d   = rd_hit_q;
    target_d   = target_q;

    case (state_q)
      ST_INIT: begin
        if (flush) begin
          init_ptr_d = '0;
        end else begin
          valid_d[init_ptr_q] = 1'b0;
          init_ptr_d          = init_ptr_q + 1'b1;
          if (init_ptr_q == A'(DEPTH - 1)) begin
            state_d = ST_READY;
          end
        end
      end
      ST_READY: begin
        if (flush) begin
          state_d    = ST_INIT;
          init_ptr_d = '0;
        end
      end
      default: begin
        state_d    = ST_INIT;
        init_ptr_d = '0;
      end
    endcase

    if (wr_accept) begin
      valid_d[wr_addr] = 1'b1;
    end

    if (rd_accept) begin
      rd_valid_d = 1'b1;
      rd_hit_d   = rd_entry_valid;
      target_d   = rd_entry_valid ? rd_entry_data : '0;
`ifdef TGT_BYPASS_EN
      if (wr_accept && (wr_addr == rd_addr)) begin
        rd_hit_d = 1'b1;
        target_d = wr_data;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_INIT;
      init_ptr_q <= '0;
      rd_valid_q <= 1'b0;
      rd_hit_q   <= 1'b0;
      target_q   <= '0;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
      rd_valid_q <= rd_valid_d;
      rd_hit_q   <= rd_hit_d;
      target_q   <= target_d;
    end
  end

  // Valid bits are cleared by the INIT sweep, not by reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && wr_accept) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // A result registered just before reset must not appear while reset is high.
  assign busy     = (state_q == ST_INIT);
  assign rd_valid = rd_valid_q && !reset;
  assign rd_hit   = rd_hit_q;
  assign target   = target_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_target_table.sv
// ============================================================================
// Module  : tb_pc_target_table
// Purpose : Directed self-checking bench for pc_target_table (D=9, A=5).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_target_table;

  localparam int D = 9;
  localparam int A = 5;

  logic         clk;
  logic         reset;
  logic         flush;
  logic         wr_en;
  logic [A-1:0] wr_addr;
  logic [D-1:0] wr_data;
  logic         rd_req;
  logic [A-1:0] rd_addr;
  logic         busy;
  logic         rd_valid;
  logic         rd_hit;
  logic [D-1:0] target;

  int n_checks;
  int n_errors;

  pc_target_table #(.D(D), .A(A)) u_dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .busy     (busy),
    .rd_valid (rd_valid),
    .rd_hit   (rd_hit),
    .target   (target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts busy cycles, checking that no result appears meanwhile.
  task automatic count_busy(input string tag, output int n);
    n = 0;
    while (busy && n < 200) begin
      check({tag, "_rdv_busy"}, 32'(rd_valid), 32'd0);
      n++;
      step();
    end
  endtask

  task automatic do_write(input int idx, input int val);
    wr_en   = 1'b1;
    wr_addr = A'(idx);
    wr_data = D'(val);
    step();
    wr_en   = 1'b0;
  endtask

  task automatic do_read(input string tag, input int idx, input int exp_hit, input int exp_tgt);
    rd_req  = 1'b1;
    rd_addr = A'(idx);
    step();
    rd_req  = 1'b0;
    check({tag, "_valid"}, 32'(rd_valid), 32'd1);
    check({tag, "_hit"}, 32'(rd_hit), 32'(exp_hit));
    check({tag, "_target"}, 32'(target), 32'(exp_tgt));
  endtask

  initial begin
    int n;
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1; flush = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_req = 1'b0; rd_addr = '0;
    step();
    step();
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_rdv", 32'(rd_valid), 32'd0);
    check("rst_hit", 32'(rd_hit), 32'd0);
    check("rst_target", 32'(target), 32'd0);

    // Requests during INIT must be ignored.
    reset   = 1'b0;
    wr_en   = 1'b1; wr_addr = 5'd2; wr_data = 9'd77;
    rd_req  = 1'b1; rd_addr = 5'd1;
    count_busy("init", n);
    wr_en  = 1'b0;
    rd_req = 1'b0;
    check("init_len", 32'(n), 32'd32);
    check("init_done_rdv", 32'(rd_valid), 32'd0);

    do_write(1, 30);
    do_read("rd1", 1, 1, 30);
    step();
    check("idle_rdv", 32'(rd_valid), 32'd0);
    check("idle_hold_hit", 32'(rd_hit), 32'd1);
    check("idle_hold_tgt", 32'(target), 32'd30);

    do_read("rd7", 7, 0, 0);
    do_read("rd2_init_wr", 2, 0, 0);

    // Same-index collision.
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 9'd48;
`ifdef TGT_BYPASS_EN
    do_read("coll3", 3, 1, 48);
`else
    do_read("coll3", 3, 0, 0);
`endif
    wr_en = 1'b0;
    do_read("after_coll3", 3, 1, 48);

    // Different-index write and read in the same cycle.
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 9'd100;
    do_read("diff_rd1", 1, 1, 30);
    wr_en = 1'b0;

    // Back-to-back lookups.
    rd_req = 1'b1; rd_addr = 5'd4;
    step();
    check("b2b_a_valid", 32'(rd_valid), 32'd1);
    check("b2b_a_target", 32'(target), 32'd100);
    rd_addr = 5'd3;
    step();
    rd_req = 1'b0;
    check("b2b_b_valid", 32'(rd_valid), 32'd1);
    check("b2b_b_target", 32'(target), 32'd48);

    // Boundary indices and full-width data.
    do_write(31, 511);
    do_write(0, 1);
    do_read("rd31", 31, 1, 511);
    do_read("rd0", 0, 1, 1);

    // Flush in READY, with a write and a read in the same cycle.
    flush = 1'b1;
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 9'd9;
    rd_req = 1'b1; rd_addr = 5'd1;
    step();
    flush = 1'b0; wr_en = 1'b0; rd_req = 1'b0;
    check("flush_busy", 32'(busy), 32'd1);
    count_busy("flush", n);
    check("flush_len", 32'(n), 32'd32);
    do_read("flush_rd1", 1, 0, 0);
    do_read("flush_rd5", 5, 0, 0);

    // Flush in the middle of INIT restarts the sweep.
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int i = 0; i < 10; i++) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    count_busy("reflush", n);
    check("reflush_len", 32'(n), 32'd32);

    // Reset in the cycle after an accepted lookup.
    do_write(1, 30);
    rd_req = 1'b1; rd_addr = 5'd1;
    step();
    rd_req = 1'b0;
    reset  = 1'b1;
    #1;
    check("rst_pend_rdv", 32'(rd_valid), 32'd0);
    step();
    check("rst_pend_rdv2", 32'(rd_valid), 32'd0);
    check("rst_pend_busy", 32'(busy), 32'd1);
    check("rst_pend_target", 32'(target), 32'd0);
    check("rst_pend_hit", 32'(rd_hit), 32'd0);
    reset = 1'b0;
    count_busy("rst2", n);
    check("rst2_len", 32'(n), 32'd32);

    // Reset together with a request.
    rd_req = 1'b1; rd_addr = 5'd1; reset = 1'b1;
    step();
    rd_req = 1'b0;
    reset  = 1'b0;
    step();
    check("rst_same_rdv", 32'(rd_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
